// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: loader states, memory geometry
// and the base address the instruction memory is mapped at.
package prog_loader_pkg;

    localparam int unsigned IMEM_DEPTH = 2048;
    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CNT_W      = 2;

    // PC of instruction-memory word 0
    localparam logic [WORD_W-1:0] TEXT_BASE = 32'h0040_0000;

    typedef enum logic [2:0] {
        RX_HDR  = 3'd0,
        RX_DATA = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    // PC corresponding to an instruction-memory word index
    function automatic logic [WORD_W-1:0] word_to_pc(input logic [ADDR_W-1:0] idx);
        return TEXT_BASE + WORD_W'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk_in          - clock
//   reset           - asynchronous active-high reset
//   accept          - a byte transfer happens on this edge
//   byte_data       - the byte being transferred
//   word_c          - full word including the byte currently presented
//                     (meaningful when word_complete_c is high)
//   word_complete_c - the 4th byte of a word is being accepted this cycle
module byte_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_complete_c
);

    localparam int unsigned HOLD_W = WORD_W - BYTE_W;

    logic [CNT_W-1:0]  byte_cnt;
    // Only the three earlier bytes need storage; the 4th is used straight
    // from the input so the word is usable on its acceptance edge.
    logic [HOLD_W-1:0] hold;

    // Byte counter wraps 3 -> 0; a byte_valid gap simply leaves both untouched
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            hold     <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            hold     <= {byte_data, hold[HOLD_W-1:BYTE_W]};
        end
    end

    // First byte received ends up in bits 7:0
    assign word_c          = {byte_data, hold};
    assign word_complete_c = accept && (byte_cnt == CNT_W'(3));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a byte stream (4-byte little-endian
// word count N followed by N little-endian words), writes the words to
// instruction memory starting at index 0 and releases the CPU reset once
// the whole program has been written.
// Ports:
//   clk_in     - clock, all state updates on rising edge
//   reset      - asynchronous active-high reset
//   byte_valid - incoming program byte present
//   byte_data  - incoming program byte
//   byte_ready - loader accepts a byte (transfer when valid && ready)
//   imem_we    - instruction-memory write strobe (one cycle per word)
//   imem_addr  - instruction-memory word index (0 = TEXT_BASE)
//   imem_wdata - word to be written
//   cpu_rst    - CPU reset, held until the load completes
//   load_done  - load completed successfully
//   load_err   - header word count exceeded the memory depth
module prog_loader #(
    parameter int unsigned IMEM_DEPTH = prog_loader_pkg::IMEM_DEPTH,
    parameter int unsigned ADDR_W     = prog_loader_pkg::ADDR_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    import prog_loader_pkg::*;

    // One extra bit so that N = IMEM_DEPTH fits
    localparam int unsigned IDX_W = ADDR_W + 1;

    state_t            state;
    state_t            nxt;
    logic [IDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  n_words;
    logic              accept_c;
    logic [WORD_W-1:0] word_c;
    logic              word_complete_c;
    logic              last_word_c;

    assign accept_c    = byte_valid && byte_ready;
    assign last_word_c = (word_idx + IDX_W'(1)) == n_words;

    byte_assembler u_asm (
        .clk_in          (clk_in),
        .reset           (reset),
        .accept          (accept_c),
        .byte_data       (byte_data),
        .word_c          (word_c),
        .word_complete_c (word_complete_c)
    );

    // Next-state decode
    always_comb begin
        nxt = state;
        unique case (state)
            RX_HDR: begin
                if (word_complete_c) begin
                    if (word_c == '0) begin
                        nxt = DONE;
                    end else if (word_c > WORD_W'(IMEM_DEPTH)) begin
                        nxt = ERROR;
                    end else begin
                        nxt = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (word_complete_c) begin
                    nxt = WRITE;
                end
            end
            WRITE: begin
                nxt = last_word_c ? DONE : RX_DATA;
            end
            DONE:    nxt = DONE;
            ERROR:   nxt = ERROR;
            default: nxt = RX_HDR;
        endcase
    end

    // State, datapath and outputs; outputs are decoded from the next state
    // so they are registered yet line up with the state they belong to.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= RX_HDR;
            word_idx   <= '0;
            n_words    <= '0;
            byte_ready <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= nxt;
            byte_ready <= (nxt == RX_HDR) || (nxt == RX_DATA);
            imem_we    <= (nxt == WRITE);
            cpu_rst    <= (nxt != DONE);
            load_done  <= (nxt == DONE);
            load_err   <= (nxt == ERROR);

            if ((state == RX_HDR) && word_complete_c) begin
                n_words <= IDX_W'(word_c);
            end

            // Address/data captured only when a word completes, so they
            // stay stable outside the WRITE cycle.
            if ((state == RX_DATA) && word_complete_c) begin
                imem_wdata <= word_c;
                imem_addr  <= word_idx[ADDR_W-1:0];
            end

            if ((state == WRITE) && !last_word_c) begin
                word_idx <= word_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte-stream driver, write monitor and
// one task per scenario with hand-computed expectations.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [10:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc          = 0;
    bit  prev_we      = 1'b0;
    bit  dbl_we       = 1'b0;
    bit  rst_low_seen = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.IMEM_DEPTH(2048), .ADDR_W(11)) dut (
        .clk_in     (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // Write monitor: records every write strobe and flags multi-cycle strobes
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (imem_we === 1'b1) begin
                wq.push_back('{imem_addr, imem_wdata, cyc});
                if (prev_we) dbl_we = 1'b1;
            end
            prev_we = (imem_we === 1'b1);
            if (cpu_rst !== 1'b1) rst_low_seen = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (byte_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL byte_accept: byte_ready=%b after %0d cycles, required 1", byte_ready, waited);
        end else begin
            @(posedge clk);
        end
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'h5a;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        int g;
        for (int k = 0; k < 4; k++) begin
            g = gaps ? int'($urandom_range(3, 0)) : 0;
            send_byte(w[8*k +: 8], g);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wq.delete();
        dbl_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", imem_we); end
        total++; if (imem_addr !== 11'd0) begin bad++; $display("FAIL reset_addr: got %h want 000", imem_addr); end
        total++; if (imem_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %h want 00000000", imem_wdata); end
        total++; if (cpu_rst !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", load_done); end
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", load_err); end
        total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", byte_ready); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_two_words();
        do_reset();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        @(negedge clk);
        total++;
        if (imem_we !== 1'b1 || imem_addr !== 11'd0 || imem_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL latency_w0: we=%b addr=%h data=%h want 1/000/12345678", imem_we, imem_addr, imem_wdata);
        end
        send_word(32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        total++;
        if (imem_we !== 1'b1 || imem_addr !== 11'd1 || imem_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL latency_w1: we=%b addr=%h data=%h want 1/001/deadbeef", imem_we, imem_addr, imem_wdata);
        end
        repeat (3) @(negedge clk);
        total++; if (wq.size() != 2) begin bad++; $display("FAIL two_count: got %0d writes want 2", wq.size()); end
        if (wq.size() >= 2) begin
            total++;
            if (wq[0].addr !== 11'd0 || wq[0].data !== 32'h1234_5678) begin
                bad++; $display("FAIL two_w0: got %h/%h want 000/12345678", wq[0].addr, wq[0].data);
            end
            total++;
            if (wq[1].addr !== 11'd1 || wq[1].data !== 32'hDEAD_BEEF) begin
                bad++; $display("FAIL two_w1: got %h/%h want 001/deadbeef", wq[1].addr, wq[1].data);
            end
            total++;
            if (wq[1].cyc - wq[0].cyc != 5) begin
                bad++; $display("FAIL two_throughput: got %0d cycles between writes want 5", wq[1].cyc - wq[0].cyc);
            end
        end
        total++; if (dbl_we) begin bad++; $display("FAIL two_pulse: imem_we high for more than one cycle, want single"); end
        total++; if (cpu_rst !== 1'b0 || load_done !== 1'b1 || load_err !== 1'b0 || byte_ready !== 1'b0) begin
            bad++; $display("FAIL two_done: rst=%b done=%b err=%b rdy=%b want 0/1/0/0", cpu_rst, load_done, load_err, byte_ready);
        end
        total++; if (imem_we !== 1'b0 || imem_addr !== 11'd1 || imem_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL two_hold: we=%b addr=%h data=%h want 0/001/deadbeef", imem_we, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_zero_hdr();
        do_reset();
        send_word(32'h0000_0000, 1'b0);
        @(negedge clk);
        total++; if (load_done !== 1'b1 || cpu_rst !== 1'b0 || byte_ready !== 1'b0) begin
            bad++; $display("FAIL zero_done: done=%b rst=%b rdy=%b want 1/0/0", load_done, cpu_rst, byte_ready);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        total++; if (load_done !== 1'b1 || load_err !== 1'b0 || byte_ready !== 1'b0) begin
            bad++; $display("FAIL zero_terminal: done=%b err=%b rdy=%b want 1/0/0", load_done, load_err, byte_ready);
        end
        total++; if (wq.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d writes want 0", wq.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_word(32'h0000_0801, 1'b0);
        @(negedge clk);
        total++; if (load_err !== 1'b1 || byte_ready !== 1'b0 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
            bad++; $display("FAIL ovf_err: err=%b rdy=%b rst=%b done=%b want 1/0/1/0", load_err, byte_ready, cpu_rst, load_done);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        total++; if (load_err !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b0) begin
            bad++; $display("FAIL ovf_terminal: err=%b rst=%b rdy=%b want 1/1/0", load_err, cpu_rst, byte_ready);
        end
        total++; if (wq.size() != 0) begin bad++; $display("FAIL ovf_writes: got %0d writes want 0", wq.size()); end
    endtask

    task automatic test_gaps();
        do_reset();
        send_word(32'h0000_0001, 1'b1);
        send_word(32'hA5C3_0F96, 1'b1);
        repeat (3) @(negedge clk);
        total++; if (wq.size() != 1) begin bad++; $display("FAIL gap_count: got %0d writes want 1", wq.size()); end
        if (wq.size() >= 1) begin
            total++;
            if (wq[0].addr !== 11'd0 || wq[0].data !== 32'hA5C3_0F96) begin
                bad++; $display("FAIL gap_word: got %h/%h want 000/a5c30f96", wq[0].addr, wq[0].data);
            end
        end
        total++; if (load_done !== 1'b1) begin bad++; $display("FAIL gap_done: got %b want 1", load_done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rst_low_seen = 1'b0;
        send_word(32'h0000_0003, 1'b0);
        send_word(32'h1111_2222, 1'b0);
        send_word(32'h3333_4444, 1'b0);
        send_byte(8'h99, 0);
        send_byte(8'h88, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (cpu_rst !== 1'b1 || byte_ready !== 1'b1 || load_done !== 1'b0) begin
            bad++; $display("FAIL mid_reset: rst=%b rdy=%b done=%b want 1/1/0", cpu_rst, byte_ready, load_done);
        end
        @(negedge clk);
        reset = 1'b0;
        total++; if (wq.size() != 2) begin bad++; $display("FAIL mid_prior: got %0d writes want 2", wq.size()); end
        wq.delete();
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        total++; if (rst_low_seen) begin bad++; $display("FAIL mid_cpu_rst: cpu_rst dropped during interruption, want held 1"); end
        repeat (3) @(negedge clk);
        total++; if (wq.size() != 1) begin bad++; $display("FAIL mid_count: got %0d writes want 1", wq.size()); end
        if (wq.size() >= 1) begin
            total++;
            if (wq[0].addr !== 11'd0 || wq[0].data !== 32'hCAFE_F00D) begin
                bad++; $display("FAIL mid_word: got %h/%h want 000/cafef00d", wq[0].addr, wq[0].data);
            end
        end
        total++; if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin
            bad++; $display("FAIL mid_done: done=%b rst=%b want 1/0", load_done, cpu_rst);
        end
    endtask

    task automatic test_full();
        int errs = 0;
        do_reset();
        send_word(32'h0000_0800, 1'b0);
        @(negedge clk);
        total++; if (load_err !== 1'b0 || byte_ready !== 1'b1) begin
            bad++; $display("FAIL full_hdr: err=%b rdy=%b want 0/1", load_err, byte_ready);
        end
        for (int i = 0; i < 2048; i++) begin
            send_word(32'h1000_0000 + 32'(i), 1'b0);
        end
        repeat (3) @(negedge clk);
        total++; if (wq.size() != 2048) begin bad++; $display("FAIL full_count: got %0d writes want 2048", wq.size()); end
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].addr !== 11'(i) || wq[i].data !== 32'h1000_0000 + 32'(i)) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL full_data: got %0d wrong writes want 0", errs); end
        if (wq.size() >= 1) begin
            total++;
            if (wq[wq.size()-1].addr !== 11'h7FF || wq[wq.size()-1].data !== 32'h1000_07FF) begin
                bad++; $display("FAIL full_last: got %h/%h want 7ff/100007ff", wq[wq.size()-1].addr, wq[wq.size()-1].data);
            end
        end
        total++; if (load_done !== 1'b1 || cpu_rst !== 1'b0 || dbl_we) begin
            bad++; $display("FAIL full_done: done=%b rst=%b dbl=%b want 1/0/0", load_done, cpu_rst, dbl_we);
        end
    endtask

    initial begin
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        test_reset();
        test_two_words();
        test_zero_hdr();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: IMEM_DEPTH, default 2048, number of 32-bit instruction-memory words.
REQ-002 Parameter: ADDR_W, default 11, instruction-memory word-address width.
REQ-003 Port: clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: byte_valid  input  1  an incoming program byte is present.
REQ-006 Port: byte_data  input  8  incoming program byte.
REQ-007 Port: byte_ready  output  1  the loader accepts a byte; a transfer occurs when byte_valid and byte_ready are both high at a rising edge.
REQ-008 Port: imem_we  output  1  instruction-memory write strobe.
REQ-009 Port: imem_addr  output  ADDR_W  instruction-memory word index; 0 maps to PC 0x0040_0000.
REQ-010 Port: imem_wdata  output  32  word to be written.
REQ-011 Port: cpu_rst  output  1  reset to the CPU; high until the program is fully loaded.
REQ-012 Port: load_done  output  1  the load completed successfully.
REQ-013 Port: load_err  output  1  the header word count exceeded IMEM_DEPTH.

Function
REQ-014 The block SHALL implement states RX_HDR, RX_DATA, WRITE, DONE and ERROR.
REQ-015 Stream format SHALL be: 4-byte header word count N, then 4N data bytes; all words are little-endian (first byte is bits 7:0).
REQ-016 byte_ready SHALL be 1 in RX_HDR and RX_DATA, and 0 in WRITE, DONE and ERROR.
REQ-017 Acceptance of the 4th header byte SHALL latch N and move the block to:
  - DONE if N = 0;
  - ERROR if N > IMEM_DEPTH;
  - RX_DATA otherwise.
REQ-018 Acceptance of the 4th byte of a data word SHALL move the block to WRITE on that edge.
REQ-019 In WRITE, for exactly one cycle, the block SHALL drive imem_we = 1, imem_addr = current word index and imem_wdata = the assembled word.
REQ-020 On the edge that leaves WRITE, the block SHALL go to DONE if the index equals N-1; otherwise it SHALL increment the index and return to RX_DATA.
REQ-021 Write latency SHALL be one cycle from acceptance of the final byte of a word to imem_we high; sustained throughput SHALL be one word per 5 cycles.
REQ-022 imem_we SHALL be 0 in every state other than WRITE.
REQ-023 cpu_rst SHALL be 0 only in DONE; load_done SHALL be 1 only in DONE; load_err SHALL be 1 only in ERROR.
REQ-024 DONE and ERROR SHALL be terminal until reset; bytes presented in those states are not accepted.
REQ-025 A byte_valid gap mid-word SHALL stall assembly without losing partial bytes; the within-word byte counter wraps 3 -> 0.
REQ-026 imem_wdata and imem_addr SHALL hold their values outside WRITE (don't-care to the memory, stable for the bench).
REQ-027 The word index SHALL be ADDR_W+1 bits wide internally so that N = IMEM_DEPTH is representable.

Reset
REQ-028 Asserting reset SHALL immediately set: state RX_HDR, byte counter 0, word index 0, N 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, load_done 0, load_err 0.
REQ-029 Reset asserted mid-load SHALL abandon the partial load; a fresh header is expected after release, and words already written are not cleared.

Structure
REQ-030 A shared package SHALL hold the state enumeration, IMEM_DEPTH, ADDR_W and TEXT_BASE = 0x0040_0000.
REQ-031 One sub-module, byte_assembler, SHALL hold the 2-bit byte counter and the 32-bit little-endian shift/assembly register, with a word_complete pulse; the FSM lives in prog_loader.

Verification
REQ-032 Header 0x00000002, then bytes 78 56 34 12 EF BE AD DE SHALL produce writes addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF, each with imem_we high for exactly one cycle, then cpu_rst 0 and load_done 1.
REQ-033 Header 0x00000000 SHALL put the block in DONE on the edge after the 4th header byte, with no imem_we pulse.
REQ-034 Header 0x00000801 SHALL produce load_err 1, byte_ready 0, cpu_rst held at 1 and no writes.
REQ-035 Header N = 1 with random byte_valid gaps (0-3 cycles) between the data bytes SHALL produce a single correct write at addr 0.
REQ-036 reset pulsed after 2 of 3 words, then a new stream of N = 1 word 0xCAFEF00D SHALL write 0xCAFEF00D at addr 0, with cpu_rst high throughout the interruption.
REQ-037 Header N = 2048 with an incrementing data pattern SHALL end with a final write at addr 0x7FF followed by load_done 1.
